imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side master for the instruction memory: pulls a byte stream (UART/debug link) into 32-bit words, writes them into IMEM
//  through its program-load write port, and holds the core in reset until the image is complete. The fetch stage is the
//  only reader of IMEM.
// PARAMETERS
//  DEPTH_WORDS  1024  IMEM capacity in 32-bit words; images longer than this are rejected
//  WA           10    width of wr_addr, the word index (>= clog2(DEPTH_WORDS))
// PORTS
//  clk          in   1   single clock; all logic on posedge
//  reset        in   1   one clock; reset is synchronous and active-high
//  start        in   1   1-cycle pulse: re-arm for a new image (honoured only in DONE/ERR)
//  in_valid     in   1   byte available on in_data
//  in_data      in   8   stream byte
//  in_ready     out  1   loader accepts in_data this cycle
//  wr_en        out  1   1-cycle IMEM write strobe
//  wr_addr      out  WA  IMEM word index (byte address >> 2)
//  wr_data      out  32  instruction word
//  cpu_hold     out  1   active-high hold to core reset; 1 while loading or in error
//  done         out  1   image loaded, core released
//  error        out  1   image rejected; core stays held
//  words_loaded out  WA+1 count of words written for the current image
// BEHAVIOUR
//  - Reset: state=LEN, in_ready=1, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, words_loaded=0, byte_idx=0.
//  - Byte accepted iff in_valid && in_ready. Bytes are little-endian: the first byte of a group is bits[7:0].
//  - Frame: 4-byte length N (in words), then N words of 4 bytes each, then the optional 4-byte checksum.
//  - LEN: on the 4th accepted byte, latch N. If N > DEPTH_WORDS -> ERR. If N == 0 -> DONE (CSUM when checksum is compiled in).
//    Otherwise -> DATA.
//  - DATA: on the 4th byte of word k (accept cycle T), wr_en=1 in cycle T+1 with wr_addr=k, wr_data=assembled word; words_loaded
//    increments in T+1. After word N-1 -> DONE (or CSUM). wr_addr never wraps since N <= DEPTH_WORDS.
//  - DONE: in_ready=0, cpu_hold=0, done=1. After the last write, done rises at T+2 so no write coincides with core release.
//  - ERR: in_ready=0, cpu_hold=1, error=1. Partial image left in IMEM (no scrub).
//  - start in DONE/ERR: next cycle state=LEN, byte_idx=0, words_loaded=0, done=0, error=0, cpu_hold=1, in_ready=1.
//    start in LEN/DATA/CSUM is ignored.
//  - Bytes with in_valid=0 create gaps of any length; there is no timeout and partial words are held indefinitely.
//  - reset mid-image: abort immediately to reset values; core stays held.
//  - wr_en is never asserted in LEN, DONE or ERR (except the single trailing strobe from DATA).
// CONFIGURATION
//  IMEM_LOADER_CSUM_EN defined: a CSUM state follows DATA and accepts 4 bytes (LE) of expected sum = sum of all N words
//    mod 2^32 (running accumulator, cleared on re-arm). Match -> DONE, mismatch -> ERR.
//  IMEM_LOADER_CSUM_EN undefined: no CSUM state or accumulator; DATA/LEN(N==0) go straight to DONE.
// STRUCTURE
//  - Shared include riscv_defs.vh: loader state encodings (LD_LEN, LD_DATA, LD_CSUM, LD_DONE, LD_ERR) and the default
//    IMEM depth constant also used by IMEM.
//  - One sub-module, byte_assembler: 2-bit byte_idx plus a 4x8 shift register. It emits word_valid for one cycle on the
//    4th byte and is cleared by the loader on re-arm/reset.
//  - Top holds the FSM, length register, word counter, checksum accumulator and the registered output stage.
// TESTING
//  1. Reset, then stream 01 00 00 00 | 13 05 A0 00 -> one wr_en, wr_addr=0, wr_data=0x00A00513; done=1 and cpu_hold=0
//     two cycles after the last byte.
//  2. N=3 with in_valid toggling every other cycle -> wr_addr 0,1,2 in order with correct words; words_loaded=3; no extra
//     wr_en strobes.
//  3. Length 0x00000401 with DEPTH_WORDS=1024 -> error=1, cpu_hold=1, in_ready=0, zero writes. Then start -> LEN; a valid
//     N=1 image then loads.
//  4. N=0 -> DONE with no writes (without CSUM), or after 00 00 00 00 checksum (with IMEM_LOADER_CSUM_EN).
//  5. With IMEM_LOADER_CSUM_EN, words 0x00000001 and 0xFFFFFFFF: checksum 00 00 00 00 -> done=1. Checksum 01 00 00 00
//     -> error=1.
//  6. Assert reset after 6 bytes of an N=2 image -> all outputs at reset values. A fresh N=1 image loads at wr_addr=0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants and loader state encodings for the IMEM
// program-load path.
//   IMEM_DEPTH_WORDS : default IMEM capacity in 32-bit words (also used by IMEM)
//   IMEM_WA          : default IMEM word-address width
//   ld_state_t       : loader FSM states (LD_LEN, LD_DATA, LD_CSUM, LD_DONE, LD_ERR)
package imem_loader_pkg;

  localparam int unsigned IMEM_DEPTH_WORDS = 1024;
  localparam int unsigned IMEM_WA          = 10;

  typedef enum logic [2:0] {
    LD_LEN  = 3'd0,
    LD_DATA = 3'd1,
    LD_CSUM = 3'd2,
    LD_DONE = 3'd3,
    LD_ERR  = 3'd4
  } ld_state_t;

  // States in which the loader consumes stream bytes.
  function automatic logic ld_accepting(input ld_state_t s);
    return (s == LD_LEN) || (s == LD_DATA) || (s == LD_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// imem_loader_byte_assembler: packs little-endian stream bytes into 32-bit words.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   clear          : synchronous restart of the byte position (loader re-arm)
//   accept         : a byte is consumed this cycle
//   in_data        : stream byte
//   word_valid_c   : combinational, high in the cycle the 4th byte is consumed
//   word_c         : combinational assembled word, valid with word_valid_c
module imem_loader_byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  in_data,
  output logic        word_valid_c,
  output logic [31:0] word_c
);

  logic [1:0]  byte_idx;
  // Only the first three bytes need storage; the 4th comes straight from in_data.
  logic [23:0] shreg;

  assign word_valid_c = accept && (byte_idx == 2'd3);
  assign word_c       = {in_data, shreg};

  // Byte position and right-shifting byte store (first byte ends up in [7:0]).
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_idx <= 2'd0;
      shreg    <= 24'd0;
    end else if (accept) begin
      byte_idx <= byte_idx + 2'd1;
      shreg    <= {in_data, shreg[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: pulls a byte stream into 32-bit words, writes them into IMEM via
// the program-load port and holds the core in reset until the image is complete.
// Frame: 4-byte LE length N (words), N LE words, optional 4-byte LE checksum.
// Build option: IMEM_LOADER_CSUM_EN adds a trailing checksum (sum of words mod 2^32).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start                 : re-arm pulse, honoured in DONE/ERR only
//   in_valid/in_data      : byte stream input; in_ready is the accept handshake
//   wr_en/wr_addr/wr_data : IMEM write strobe, word index and data
//   cpu_hold              : core reset hold (1 while loading or in error)
//   done/error            : image loaded / image rejected
//   words_loaded          : words written for the current image
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int unsigned WA          = IMEM_WA
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [WA-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [WA:0]   words_loaded
);

`ifdef IMEM_LOADER_CSUM_EN
  localparam ld_state_t AFTER_DATA = LD_CSUM;
`else
  localparam ld_state_t AFTER_DATA = LD_DONE;
`endif

  ld_state_t   state;
  ld_state_t   next_state;
  logic        rearm_c;
  logic        accept_c;
  logic        word_valid_c;
  logic [31:0] word_c;
  logic        last_word_c;
  logic [WA:0] len_q;
`ifdef IMEM_LOADER_CSUM_EN
  logic [31:0] csum_q;
`endif

  assign accept_c    = in_valid && in_ready;
  assign last_word_c = ((words_loaded + (WA+1)'(1)) == len_q);

  imem_loader_byte_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear        (rearm_c),
    .accept       (accept_c),
    .in_data      (in_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // Next-state logic.
  always_comb begin
    next_state = state;
    rearm_c    = 1'b0;
    case (state)
      LD_LEN: begin
        if (word_valid_c) begin
          if (word_c > 32'(DEPTH_WORDS)) next_state = LD_ERR;
          else if (word_c == 32'd0)      next_state = AFTER_DATA;
          else                           next_state = LD_DATA;
        end
      end
      LD_DATA: begin
        if (word_valid_c && last_word_c) next_state = AFTER_DATA;
      end
`ifdef IMEM_LOADER_CSUM_EN
      LD_CSUM: begin
        if (word_valid_c) next_state = (word_c == csum_q) ? LD_DONE : LD_ERR;
      end
`endif
      LD_DONE, LD_ERR: begin
        if (start) begin
          next_state = LD_LEN;
          rearm_c    = 1'b1;
        end
      end
      default: next_state = LD_ERR;
    endcase
  end

  // State register, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LD_LEN;
      in_ready     <= 1'b1;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 32'd0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len_q        <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q       <= 32'd0;
`endif
    end else begin
      state    <= next_state;
      in_ready <= ld_accepting(next_state);
      // done waits one cycle in DONE so the final write never overlaps core release.
      done     <= (state == LD_DONE) && (next_state == LD_DONE);
      cpu_hold <= !((state == LD_DONE) && (next_state == LD_DONE));
      error    <= (next_state == LD_ERR);
      wr_en    <= word_valid_c && (state == LD_DATA);

      if (word_valid_c && (state == LD_LEN)) len_q <= word_c[WA:0];

      if (word_valid_c && (state == LD_DATA)) begin
        wr_addr      <= words_loaded[WA-1:0];
        wr_data      <= word_c;
        words_loaded <= words_loaded + (WA+1)'(1);
`ifdef IMEM_LOADER_CSUM_EN
        csum_q       <= csum_q + word_c;
`endif
      end

      if (rearm_c) begin
        words_loaded <= '0;
`ifdef IMEM_LOADER_CSUM_EN
        csum_q       <= 32'd0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader. Frames are
// built from random words; expected writes, final status and timing come from
// the framing rules (queue of words, plain sum for the checksum).
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WA    = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wr_en;
  logic [WA-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [WA:0]   words_loaded;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [WA-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t wr_q[$];

  imem_loader #(.DEPTH_WORDS(DEPTH), .WA(WA)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: records every IMEM write; a write must never coincide with done.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_q.push_back({wr_addr, wr_data});
      check("write_while_done", 64'(done), 64'(0));
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, ".in_ready"},     64'(in_ready),     64'(1));
    check({tag, ".wr_en"},        64'(wr_en),        64'(0));
    check({tag, ".wr_addr"},      64'(wr_addr),      64'(0));
    check({tag, ".wr_data"},      64'(wr_data),      64'(0));
    check({tag, ".cpu_hold"},     64'(cpu_hold),     64'(1));
    check({tag, ".done"},         64'(done),         64'(0));
    check({tag, ".error"},        64'(error),        64'(0));
    check({tag, ".words_loaded"}, 64'(words_loaded), 64'(0));
  endtask

  // Called on a negedge; returns on the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke_start);
    int guard;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = poke_start;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      start = 1'b0;
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic push_word(inout logic [7:0] q[$], input logic [31:0] w);
    for (int i = 0; i < 4; i++) q.push_back(8'(w >> (8 * i)));
  endtask

  // Sends one frame, checks writes and final status against the framing rules,
  // then re-arms with start.
  task automatic run_image(input string name, input int unsigned n, input logic [31:0] words[$],
                           input int gmin, input int gmax, input logic [31:0] csum_delta,
                           input bit poke);
    logic [7:0]  bytes[$];
    logic [31:0] sum;
    bit          exp_ok;
    int unsigned exp_writes;
    int          guard;
    int          lim;
    bytes = {};
    sum   = 32'd0;
    push_word(bytes, n);
    if (n <= DEPTH) begin
      for (int i = 0; i < int'(n); i++) begin
        push_word(bytes, words[i]);
        sum = sum + words[i];
      end
`ifdef IMEM_LOADER_CSUM_EN
      push_word(bytes, sum + csum_delta);
`endif
    end
    exp_writes = (n <= DEPTH) ? n : 0;
    exp_ok     = (n <= DEPTH);
`ifdef IMEM_LOADER_CSUM_EN
    exp_ok     = exp_ok && (csum_delta == 32'd0);
`endif
    wr_q.delete();
    foreach (bytes[i])
      send_byte(bytes[i], $urandom_range(gmax, gmin), poke && ($urandom_range(3, 0) == 0));

    if (exp_ok) begin
`ifndef IMEM_LOADER_CSUM_EN
      if (n > 0) check({name, ".wr_en_after_last"}, 64'(wr_en), 64'(1));
`endif
      check({name, ".done_t1"}, 64'(done), 64'(0));
      check({name, ".ready_t1"}, 64'(in_ready), 64'(0));
      @(negedge clk);
      check({name, ".done_t2"}, 64'(done), 64'(1));
      check({name, ".hold_t2"}, 64'(cpu_hold), 64'(0));
      check({name, ".error"}, 64'(error), 64'(0));
    end else begin
      guard = 0;
      while (error !== 1'b1 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      check({name, ".error"}, 64'(error), 64'(1));
      check({name, ".hold"}, 64'(cpu_hold), 64'(1));
      check({name, ".done"}, 64'(done), 64'(0));
    end

    // Offered bytes must be ignored once finished.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({name, ".in_ready_end"}, 64'(in_ready), 64'(0));
    check({name, ".words_loaded"}, 64'(words_loaded), 64'(exp_writes));
    check({name, ".n_writes"}, 64'(wr_q.size()), 64'(exp_writes));
    lim = (wr_q.size() < int'(exp_writes)) ? wr_q.size() : int'(exp_writes);
    for (int i = 0; i < lim; i++) begin
      check($sformatf("%s.addr[%0d]", name, i), 64'(wr_q[i].addr), 64'(i));
      check($sformatf("%s.data[%0d]", name, i), 64'(wr_q[i].data), 64'(words[i]));
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, ".rearm_ready"}, 64'(in_ready), 64'(1));
    check({name, ".rearm_done"},  64'(done),     64'(0));
    check({name, ".rearm_error"}, 64'(error),    64'(0));
    check({name, ".rearm_hold"},  64'(cpu_hold), 64'(1));
    check({name, ".rearm_words"}, 64'(words_loaded), 64'(0));
  endtask

  initial begin
    logic [31:0] w[$];
    logic [31:0] none[$];
    logic [7:0]  partial[$];
    int unsigned n;
    none     = {};
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // Single-word image with exact write and release timing.
    w = {32'h00A00513};
    run_image("t1", 1, w, 0, 0, 32'd0, 1'b0);

    // Three words with a one-cycle gap between every byte.
    w = {32'($urandom), 32'($urandom), 32'($urandom)};
    run_image("t2", 3, w, 1, 1, 32'd0, 1'b0);

    // Oversized length is rejected, then a valid image loads.
    run_image("t3_over", DEPTH + 1, none, 0, 0, 32'd0, 1'b0);
    w = {32'($urandom)};
    run_image("t3_after", 1, w, 0, 2, 32'd0, 1'b0);

    // Empty image.
    run_image("t4_zero", 0, none, 0, 1, 32'd0, 1'b0);

`ifdef IMEM_LOADER_CSUM_EN
    // Checksum that wraps to zero, then an off-by-one checksum.
    w = {32'h00000001, 32'hFFFFFFFF};
    run_image("t5_good", 2, w, 0, 0, 32'd0, 1'b0);
    run_image("t5_bad", 2, w, 0, 0, 32'd1, 1'b0);
`endif

    // Reset after 6 bytes of an N=2 image, then a fresh image from address 0.
    partial = {};
    push_word(partial, 32'd2);
    push_word(partial, 32'($urandom));
    wr_q.delete();
    for (int i = 0; i < 6; i++) send_byte(partial[i], $urandom_range(1, 0), 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("t6_reset");
    check("t6_no_writes", 64'(wr_q.size()), 64'(0));
    reset = 1'b0;
    w = {32'($urandom)};
    run_image("t6_fresh", 1, w, 0, 1, 32'd0, 1'b0);

    // Full-capacity image: last address is DEPTH-1, no wrap.
    w = {};
    for (int i = 0; i < int'(DEPTH); i++) w.push_back(32'($urandom));
    run_image("full", DEPTH, w, 0, 0, 32'd0, 1'b0);

    // Random images with random gaps and ignored start pulses mid-image.
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(8, 0);
      w = {};
      for (int i = 0; i < int'(n); i++) w.push_back(32'($urandom));
      run_image($sformatf("rand%0d", k), n, w, 0, 3,
                ($urandom_range(2, 0) == 0) ? 32'($urandom_range(255, 1)) : 32'd0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
